// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//
// Parametrised data memory sitting between the load/store unit and the rest
// of the core. Accesses use a valid/ready handshake, writes honour a per-bit
// mask, reads return registered data one cycle after acceptance together with
// an rvalid strobe, and addresses at or above DEPTH raise a one-cycle
// addr_err strobe instead of touching the array. After reset, or on a
// clear_req, a sequential clear walks every word and writes INIT_VALUE,
// taking exactly DEPTH cycles.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   reset         synchronous, active-high; restarts the clear
//   clear_req     one-cycle request to re-clear the whole memory
//   req_valid     access request present
//   req_ready     block accepts a request this cycle
//   write_enable  1 = write access, 0 = read access
//   address       word address (ADDR_WIDTH bits)
//   data_in       write data (DATA_WIDTH bits)
//   wmask         per-bit write mask, 1 = bit is written
//   rdata         registered read data
//   rvalid        one-cycle strobe, rdata is valid
//   addr_err      one-cycle strobe, accepted access was out of range
//   busy          clear in progress
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] wmask,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  addr_err,
  output logic                  busy
);

  // Index width of the implemented array; never wider than the address port
  // because DEPTH <= 2**ADDR_WIDTH.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The clear pointer carries one extra bit so DEPTH = 2**ADDR_WIDTH can be
  // represented and compared without wrapping.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_PTR  = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH+1)'(1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   clear_ptr_q, clear_ptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  addr_err_q, addr_err_d;

  logic                  ready_int;
  logic                  accept;
  logic                  in_range;
  logic [IDX_W-1:0]      acc_idx;

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Full-width range check: the address is zero-extended rather than
  // truncated so out-of-range addresses never alias onto real words.
  assign in_range  = ({1'b0, address} < DEPTH_EXT);
  assign acc_idx   = address[IDX_W-1:0];

  // A clear request wins over an access presented in the same cycle.
  assign ready_int = (state_q == READY) && !clear_req;
  assign accept    = req_valid && ready_int;

  // Outputs are forced to their reset values for as long as reset is held,
  // including the very first reset cycle before the registers have settled.
  assign req_ready = ready_int && !reset;
  assign busy      = (state_q == CLEAR) || reset;
  assign rvalid    = rvalid_q && !reset;
  assign addr_err  = addr_err_q && !reset;
  assign rdata     = reset ? '0 : rdata_q;

  // Next-state logic: the clear walk in CLEAR, request handling in READY.
  // The memory write port is shared between the clear walk and accepted
  // writes; the read-modify-write merge uses the current word so a mask of
  // zero leaves the word untouched.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    addr_err_d  = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clear_ptr_q[IDX_W-1:0];
        mem_wdata = INIT_VALUE;
        if (clear_ptr_q == LAST_PTR) begin
          state_d     = READY;
          clear_ptr_d = '0;
        end else begin
          clear_ptr_d = clear_ptr_q + PTR_ONE;
        end
      end

      READY: begin
        if (clear_req) begin
          state_d     = CLEAR;
          clear_ptr_d = '0;
        end else if (accept) begin
          addr_err_d = !in_range;
          if (write_enable) begin
            if (in_range) begin
              mem_we    = 1'b1;
              mem_waddr = acc_idx;
              mem_wdata = (mem[acc_idx] & ~wmask) | (data_in & wmask);
            end
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = in_range ? mem[acc_idx] : '0;
          end
        end
      end

      default: begin
        state_d     = CLEAR;
        clear_ptr_d = '0;
      end
    endcase
  end

  // Control and read-data registers. Reset restarts the clear from word 0
  // and drops any pending read or error strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      clear_ptr_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Storage array. It has no reset of its own: contents only change through
  // the clear walk or accepted writes, and reset itself leaves them alone.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
//
// Drives two instances of data_memory_ctrl from the same stimulus: one with
// the default DEPTH of 256 and one with DEPTH 200, so the out-of-range path
// is exercised alongside the normal one. A plain array model of each memory
// predicts read data, strobes and error flags.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_req;
  logic       req_valid;
  logic       write_enable;
  logic [7:0] address;
  logic [7:0] data_in;
  logic [7:0] wmask;

  logic [7:0] rdataW  [2];
  logic       readyW  [2];
  logic       rvalidW [2];
  logic       errW    [2];
  logic       busyW   [2];

  int checks = 0;
  int errors = 0;

  int         depthOf [2] = '{256, 200};
  logic [7:0] modelMem [2][256];
  logic [7:0] lastRd [2];

  always #5 clk = ~clk;

  data_memory_ctrl dut0 (
    .clk          (clk),
    .reset        (reset),
    .clear_req    (clear_req),
    .req_valid    (req_valid),
    .req_ready    (readyW[0]),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .wmask        (wmask),
    .rdata        (rdataW[0]),
    .rvalid       (rvalidW[0]),
    .addr_err     (errW[0]),
    .busy         (busyW[0])
  );

  data_memory_ctrl #(.DEPTH(200)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .clear_req    (clear_req),
    .req_valid    (req_valid),
    .req_ready    (readyW[1]),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .wmask        (wmask),
    .rdata        (rdataW[1]),
    .rvalid       (rvalidW[1]),
    .addr_err     (errW[1]),
    .busy         (busyW[1])
  );

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int k,
                             input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, k, observed, expected);
    end
  endtask

  task automatic modelClear();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++)
        modelMem[k][a] = 8'h00;
  endtask

  // Present one access, predict its effect from the model, clock it in and
  // compare the strobes and read data in the following cycle.
  task automatic applyStimulus(input logic we, input logic [7:0] addr,
                               input logic [7:0] data, input logic [7:0] mask);
    logic expErr [2];
    req_valid    = 1'b1;
    write_enable = we;
    address      = addr;
    data_in      = data;
    wmask        = mask;
    for (int k = 0; k < 2; k++) begin
      checkOutput("req_ready", k, 32'(readyW[k]), 32'd1);
      expErr[k] = (int'(addr) >= depthOf[k]);
      if (we) begin
        if (!expErr[k])
          modelMem[k][addr] = (modelMem[k][addr] & ~mask) | (data & mask);
      end else begin
        lastRd[k] = expErr[k] ? 8'h00 : modelMem[k][addr];
      end
    end
    step();
    for (int k = 0; k < 2; k++) begin
      checkOutput("rvalid", k, 32'(rvalidW[k]), 32'(!we));
      checkOutput("addr_err", k, 32'(errW[k]), 32'(expErr[k]));
      checkOutput("rdata", k, 32'(rdataW[k]), 32'(lastRd[k]));
    end
  endtask

  task automatic idleCycle();
    req_valid = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      checkOutput("idle_rvalid", k, 32'(rvalidW[k]), 32'd0);
      checkOutput("idle_addr_err", k, 32'(errW[k]), 32'd0);
      checkOutput("idle_rdata", k, 32'(rdataW[k]), 32'(lastRd[k]));
    end
  endtask

  // Count busy cycles of both instances until both are ready, checking that
  // no read strobe escapes during the clear.
  task automatic waitClear();
    int c0 = 0;
    int c1 = 0;
    int guard = 0;
    while ((busyW[0] || busyW[1]) && guard < 1000) begin
      if (busyW[0]) c0++;
      if (busyW[1]) c1++;
      if (guard == 0 || guard == 150) begin
        checkOutput("clr_rvalid", 0, 32'(rvalidW[0]), 32'd0);
        checkOutput("clr_rvalid", 1, 32'(rvalidW[1]), 32'd0);
        checkOutput("clr_ready", 0, 32'(readyW[0]), 32'd0);
      end
      step();
      guard++;
    end
    checkOutput("clr_timeout", 0, 32'(guard < 1000), 32'd1);
    checkOutput("busy_cycles", 0, 32'(c0), 32'd256);
    checkOutput("busy_cycles", 1, 32'(c1), 32'd200);
    checkOutput("ready_after_clear", 0, 32'(readyW[0]), 32'd1);
    checkOutput("ready_after_clear", 1, 32'(readyW[1]), 32'd1);
    modelClear();
  endtask

  initial begin
    reset        = 1'b1;
    clear_req    = 1'b0;
    req_valid    = 1'b0;
    write_enable = 1'b0;
    address      = 8'h00;
    data_in      = 8'h00;
    wmask        = 8'h00;
    lastRd       = '{8'h00, 8'h00};

    // Reset for two cycles; outputs held at their reset values.
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_busy", k, 32'(busyW[k]), 32'd1);
      checkOutput("rst_ready", k, 32'(readyW[k]), 32'd0);
      checkOutput("rst_rvalid", k, 32'(rvalidW[k]), 32'd0);
      checkOutput("rst_addr_err", k, 32'(errW[k]), 32'd0);
      checkOutput("rst_rdata", k, 32'(rdataW[k]), 32'd0);
    end
    reset = 1'b0;
    waitClear();

    // Freshly cleared words read back as zero with one-cycle latency.
    applyStimulus(1'b0, 8'd0, 8'h00, 8'h00);
    idleCycle();
    applyStimulus(1'b0, 8'd128, 8'h00, 8'h00);
    idleCycle();
    applyStimulus(1'b0, 8'd255, 8'h00, 8'h00);
    idleCycle();

    // Masked partial write.
    applyStimulus(1'b1, 8'h10, 8'hA5, 8'hFF);
    applyStimulus(1'b1, 8'h10, 8'h00, 8'h0F);
    applyStimulus(1'b0, 8'h10, 8'h00, 8'h00);
    checkOutput("masked_write", 0, 32'(rdataW[0]), 32'h0A0);
    idleCycle();

    // Read immediately after write, then back-to-back reads.
    applyStimulus(1'b1, 8'hFF, 8'h3C, 8'hFF);
    applyStimulus(1'b0, 8'hFF, 8'h00, 8'h00);
    checkOutput("raw_same_addr", 0, 32'(rdataW[0]), 32'h03C);
    applyStimulus(1'b1, 8'h01, 8'h11, 8'hFF);
    applyStimulus(1'b1, 8'h02, 8'h22, 8'hFF);
    applyStimulus(1'b0, 8'h01, 8'h00, 8'h00);
    checkOutput("b2b_first", 0, 32'(rdataW[0]), 32'h011);
    applyStimulus(1'b0, 8'h02, 8'h00, 8'h00);
    checkOutput("b2b_second_valid", 0, 32'(rvalidW[0]), 32'd1);
    checkOutput("b2b_second", 0, 32'(rdataW[0]), 32'h022);
    idleCycle();

    // Out-of-range for the DEPTH=200 instance, and its last valid word.
    applyStimulus(1'b1, 8'd210, 8'h77, 8'hFF);
    applyStimulus(1'b0, 8'd210, 8'h00, 8'h00);
    checkOutput("oor_rdata", 1, 32'(rdataW[1]), 32'h000);
    checkOutput("oor_err", 1, 32'(errW[1]), 32'd1);
    applyStimulus(1'b1, 8'd199, 8'h5A, 8'hFF);
    applyStimulus(1'b0, 8'd199, 8'h00, 8'h00);
    checkOutput("last_word", 1, 32'(rdataW[1]), 32'h05A);
    idleCycle();

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0)
        idleCycle();
      else
        applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    idleCycle();

    // Clear request beats a simultaneous read.
    applyStimulus(1'b1, 8'd5, 8'h55, 8'hFF);
    idleCycle();
    clear_req    = 1'b1;
    req_valid    = 1'b1;
    write_enable = 1'b0;
    address      = 8'd5;
    #1;
    checkOutput("clr_req_ready", 0, 32'(readyW[0]), 32'd0);
    checkOutput("clr_req_ready", 1, 32'(readyW[1]), 32'd0);
    step();
    clear_req = 1'b0;
    req_valid = 1'b0;
    checkOutput("clr_no_rvalid", 0, 32'(rvalidW[0]), 32'd0);
    waitClear();
    applyStimulus(1'b0, 8'd5, 8'h00, 8'h00);
    checkOutput("cleared_word", 0, 32'(rdataW[0]), 32'h000);
    idleCycle();

    // Reset in the middle of a clear restarts it from word 0.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 99; i++) step();
    checkOutput("mid_clear_busy", 0, 32'(busyW[0]), 32'd1);
    reset = 1'b1;
    step();
    step();
    checkOutput("mid_rst_rdata", 0, 32'(rdataW[0]), 32'd0);
    checkOutput("mid_rst_rvalid", 0, 32'(rvalidW[0]), 32'd0);
    reset = 1'b0;
    lastRd = '{8'h00, 8'h00};
    waitClear();
    applyStimulus(1'b0, 8'd199, 8'h00, 8'h00);
    idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
